// File: rtl/vram_writer.sv
// Write-side engine for the 512-byte video frame memory: buffers CPU byte
// stores in a FIFO, performs a full-screen fill, and optionally gates writes to blanking.
module vram_writer #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          GATE_BLANK = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_req_ready,
  input  logic              i_fill_start,
  input  logic [DATA_W-1:0] i_fill_color,
  input  logic              i_blank,
  output logic              o_vram_we,
  output logic [ADDR_W-1:0] o_vram_waddr,
  output logic [DATA_W-1:0] o_vram_wdata,
  output logic              o_busy,
  output logic              o_fill_done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [ADDR_W-1:0] r_fill_cnt, w_fill_cnt_nxt;
  logic [DATA_W-1:0] r_fill_color, w_fill_color_nxt;
  logic              r_req_ready, r_vram_we, r_busy, r_fill_done;
  logic [ADDR_W-1:0] r_vram_waddr, w_waddr_nxt;
  logic [DATA_W-1:0] r_vram_wdata, w_wdata_nxt;
  logic              w_we_nxt, w_done_nxt, w_pop, w_push, w_ok, w_empty;

  assign w_ok    = (GATE_BLANK == 1'b0) | i_blank;
  assign w_empty = (r_count == '0);
  assign w_push  = i_req_valid & r_req_ready;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_pop            = 1'b0;
    w_we_nxt         = 1'b0;
    w_waddr_nxt      = r_vram_waddr;
    w_wdata_nxt      = r_vram_wdata;
    w_done_nxt       = 1'b0;
    w_fill_cnt_nxt   = r_fill_cnt;
    w_fill_color_nxt = r_fill_color;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && w_ok) begin
          w_pop       = 1'b1;
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_fifo_addr[r_rd_ptr];
          w_wdata_nxt = r_fifo_data[r_rd_ptr];
        end
        if (i_fill_start) begin
          w_state_nxt      = S_FILL;
          w_fill_color_nxt = i_fill_color;
          w_fill_cnt_nxt   = '0;
        end
      end
      S_FILL: begin
        if (w_ok) begin
          w_we_nxt       = 1'b1;
          w_waddr_nxt    = r_fill_cnt;
          w_wdata_nxt    = r_fill_color;
          w_fill_cnt_nxt = r_fill_cnt + ADDR_W'(1);
          if (r_fill_cnt == {ADDR_W{1'b1}}) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_fill_cnt   <= '0;
      r_fill_color <= '0;
      r_req_ready  <= 1'b1;
      r_vram_we    <= 1'b0;
      r_vram_waddr <= '0;
      r_vram_wdata <= '0;
      r_busy       <= 1'b0;
      r_fill_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr     <= r_rd_ptr + PTR_W'(w_pop);
      r_count      <= w_count_nxt;
      r_fill_cnt   <= w_fill_cnt_nxt;
      r_fill_color <= w_fill_color_nxt;
      r_req_ready  <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
      r_vram_we    <= w_we_nxt;
      r_vram_waddr <= w_waddr_nxt;
      r_vram_wdata <= w_wdata_nxt;
      // Held high through the final write so busy drops the cycle after it
      r_busy       <= (w_state_nxt == S_FILL) | (w_count_nxt != '0) | w_we_nxt;
      r_fill_done  <= w_done_nxt;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= i_req_addr;
      r_fifo_data[r_wr_ptr] <= i_req_data;
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_vram_we    = r_vram_we;
  assign o_vram_waddr = r_vram_waddr;
  assign o_vram_wdata = r_vram_wdata;
  assign o_busy       = r_busy;
  assign o_fill_done  = r_fill_done;

endmodule

// File: doc/vram_writer.md
# vram_writer

Write-side engine for the 512-byte video frame memory scanned out by the VGA display path; one byte is one 8x8 on-screen block, 16 blocks per row, 32 rows. It accepts byte stores from the CPU bus through a valid/ready handshake, buffers them in a small FIFO and issues them to the frame memory's write port. It also provides a hardware full-screen fill. All memory writes can be restricted to display blanking so scan-out never reads a half-updated frame.

## Interface
- ADDR_W, 9, frame memory address width (512 entries; address = row*16 + col)
- DATA_W, 8, pixel/colour byte width
- FIFO_DEPTH, 4, pending-store buffer depth (power of two, >= 2)
- GATE_BLANK, 1, 1 = writes issued only while blank=1; 0 = writes issued whenever possible

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU store request
- req_addr  in  ADDR_W  target block address
- req_data  in  DATA_W  colour byte
- req_ready  out  1  FIFO can accept; transfer on req_valid & req_ready at rising edge
- fill_start  in  1  one-cycle pulse: start full-screen fill
- fill_color  in  DATA_W  fill byte, sampled on the accepted fill_start edge
- blank  in  1  1 = display not reading frame memory (outside active window)
- vram_we  out  1  frame memory write enable (registered)
- vram_waddr  out  ADDR_W  write address (registered)
- vram_wdata  out  DATA_W  write data (registered)
- busy  out  1  fill in progress or FIFO non-empty
- fill_done  out  1  one-cycle pulse after the last fill write

## Operation
- States: IDLE, FILL.
- Issue permission ok = (GATE_BLANK==0) | blank.
- IDLE: if FIFO non-empty and ok, pop the head and register it onto vram_we/waddr/wdata; else vram_we=0.
- IDLE + fill_start: latch fill_color, clear fill counter to 0, go to FILL. If a pop happens on the same edge, that pop still completes.
- FILL: each cycle with ok, write fill_color to address = counter, then counter+1. After the write to address 511 is issued, return to IDLE; fill_done pulses in the cycle where vram_we for address 511 is high. If ok=0, stall with no write and counter held.
- fill_start while in FILL: ignored; colour and counter unchanged.
- The FIFO keeps accepting stores during FILL but is not drained until FILL ends. Stores queued during a fill therefore overwrite the fill result.
- FIFO order is strict: the last store to an address wins.
- req_ready = !full and does not account for a same-cycle pop. A push and a pop on one edge are both legal when not full.
- req_valid while not ready: request not taken; the requester holds it.
- Counter and FIFO pointers wrap modulo their size. The fill counter is ADDR_W bits, and the terminal test is counter == 2^ADDR_W-1.

## Timing
- Reset (rst=0, asynchronous): state IDLE, FIFO empty, fill counter 0, vram_we=0, vram_waddr=0, vram_wdata=0, fill_done=0, busy=0, req_ready=1.
- A reset mid-fill or with a non-empty FIFO discards all pending work. No write is issued after reset asserts.
- Store latency, FIFO empty and ok=1: accepted at edge N, vram_we high in cycle N+1 to N+2, memory captures at edge N+2.
- Throughput: one write per cycle while ok=1.
- Fill: 512 write cycles with ok=1. Accepted at edge N, vram_we first high after edge N+1 with address 0, last write (address 511) captured at edge N+513.
- busy is registered from the next state and FIFO count. It deasserts in the cycle after the last vram_we.
- vram_we is never high while GATE_BLANK=1 and blank was 0 at the issuing edge.

## Test plan
- Reset then single store addr=0x011, data=0xE0, blank=1 -> req_ready=1 throughout. One vram_we pulse with waddr=0x011, wdata=0xE0, captured 2 edges after accept. busy falls the cycle after.
- Five back-to-back stores (addr 1..5) with blank=0 and GATE_BLANK=1 -> req_ready drops after the 4th, no vram_we. Raise blank -> writes to 1,2,3,4 on consecutive cycles, then the 5th store is accepted and written to address 5.
- fill_start with fill_color=0x1C, blank=1 -> exactly 512 writes to addresses 0x000..0x1FF, all with data 0x1C. fill_done is a single pulse, coincident with the write to 0x1FF.
- Fill with blank toggling 10 cycles on / 10 off -> no vram_we while blank=0, addresses contiguous with no skips or repeats, 512 writes total.
- Store addr=0x020, data=0xFF accepted mid-fill; second fill_start mid-fill with colour 0x03 -> the second fill is ignored. After 0x1FF the store writes 0xFF to 0x020. Final memory is 0x1C except 0x020 = 0xFF.
- Assert rst at fill address 0x100 with 2 stores queued -> outputs go to reset values immediately. No further writes. busy=0, req_ready=1.
